fft256_seq_ctrl: RTL

//  Sequencer for an in-place, iterative radix-2 256-point FFT built around one shared pipelined butterfly and a

---
 rtl/fft256_seq_ctrl_if.sv | 52 +++++
 rtl/fft256_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft256_seq_ctrl_if.sv
// Signal bundle between the FFT sequencer and its surroundings: sample input
// handshake, RAM write port, butterfly issue/write-back and unload read port.
//
// Handshake: an input sample transfers on a rising edge where valid_in=1 and
// in_ready=1; in_ready is a function of the sequencer state only and never
// depends on valid_in. sop_in and inv_in are meaningful only with valid_in.
// Everything the sequencer drives out (wr_*, bf_*, wb_*, rd_*, valid_out)
// is a strobe without backpressure: the consumer must take it that cycle.
interface fft256_seq_ctrl_if #(
    parameter int LOGN = 8
);
    localparam int SW = $clog2(LOGN);

    logic            valid_in;
    logic            sop_in;
    logic            inv_in;
    logic            in_ready;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr;
    logic            bf_en;
    logic [LOGN-1:0] addr_p;
    logic [LOGN-1:0] addr_q;
    logic [LOGN-2:0] tw_idx;
    logic [SW-1:0]   stage;
    logic            wb_en;
    logic [LOGN-1:0] wb_addr_p;
    logic [LOGN-1:0] wb_addr_q;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr;
    logic            valid_out;
    logic            sop_out;
    logic            inv_out;
    logic            busy;
    logic            err_sop;
    logic [2:0]      dbg_state;

    // Source of samples / consumer of the control strobes
    modport master (
        output valid_in, sop_in, inv_in,
        input  in_ready, wr_en, wr_addr, bf_en, addr_p, addr_q, tw_idx, stage,
               wb_en, wb_addr_p, wb_addr_q, rd_en, rd_addr, valid_out, sop_out,
               inv_out, busy, err_sop, dbg_state
    );

    // The sequencer itself
    modport slave (
        input  valid_in, sop_in, inv_in,
        output in_ready, wr_en, wr_addr, bf_en, addr_p, addr_q, tw_idx, stage,
               wb_en, wb_addr_p, wb_addr_q, rd_en, rd_addr, valid_out, sop_out,
               inv_out, busy, err_sop, dbg_state
    );
endinterface

// File: rtl/fft256_seq_ctrl.sv
// Address/enable sequencer for an in-place radix-2 FFT around one pipelined
// butterfly and a dual-port sample RAM. Frames are written in bit-reversed
// order, processed stage by stage with a drain gap so each stage's results
// are written back before the next stage reads them, then read out in
// natural order. No datapath arithmetic lives here.
module fft256_seq_ctrl #(
    parameter int N      = 256,
    parameter int LOGN   = 8,
    parameter int BF_LAT = 4,
    parameter int RD_LAT = 1
) (
    input logic              clk,
    input logic              rst_n,
    fft256_seq_ctrl_if.slave bus
);
    localparam int SW = $clog2(LOGN);     // stage index width
    localparam int BW = LOGN - 1;         // butterfly index width (N/2 per stage)
    localparam int DW = $clog2(BF_LAT) + 1;
    localparam int TW = $clog2(RD_LAT) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_UNLOAD  = 3'd4
    } state_t;

    state_t          state;
    logic [LOGN-1:0] cnt;        // samples accepted in the current frame
    logic [BW-1:0]   b;          // butterfly index within the stage
    logic [DW-1:0]   dcnt;       // drain cycles elapsed
    logic [TW-1:0]   tcnt;       // unload tail cycles elapsed
    logic            inv_q;
    logic            err_q;
    logic            bf_en_q;
    logic [LOGN-1:0] addr_p_q;
    logic [LOGN-1:0] addr_q_q;
    logic [BW-1:0]   tw_q;
    logic [SW-1:0]   stage_q;
    logic            rd_en_q;
    logic [LOGN-1:0] rd_addr_q;

    logic [BF_LAT-1:0]           wb_en_sr;
    logic [BF_LAT-1:0][LOGN-1:0] wb_p_sr;
    logic [BF_LAT-1:0][LOGN-1:0] wb_q_sr;
    logic [RD_LAT-1:0]           rd_en_sr;
    logic [RD_LAT-1:0]           rd_sop_sr;

    logic [BW-1:0]   b_next;
    logic [SW-1:0]   stage_next;

    assign b_next     = b + BW'(1);
    assign stage_next = stage_q + SW'(1);

    // Mirror the sample counter so index 1 lands at address N/2, and so on.
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = x[LOGN-1-i];
        end
        return r;
    endfunction

    // Distance between the two operands of a butterfly in stage s.
    function automatic logic [LOGN-1:0] half_of(input logic [SW-1:0] s);
        return LOGN'(1) << s;
    endfunction

    // Position of butterfly bi inside its group of 2^s.
    function automatic logic [BW-1:0] j_of(input logic [BW-1:0] bi, input logic [SW-1:0] s);
        return bi & BW'(half_of(s) - LOGN'(1));
    endfunction

    // Upper operand: butterfly index with a zero bit inserted at position s.
    function automatic logic [LOGN-1:0] calc_p(input logic [BW-1:0] bi, input logic [SW-1:0] s);
        return ((LOGN'(bi) >> s) << (int'(s) + 1)) + LOGN'(j_of(bi, s));
    endfunction

    // Twiddle index: group position scaled up to the N/2-entry ROM.
    function automatic logic [BW-1:0] calc_tw(input logic [BW-1:0] bi, input logic [SW-1:0] s);
        return j_of(bi, s) << (BW - int'(s));
    endfunction

    // Input side is combinational so a sample is written in the cycle it is offered.
    assign bus.in_ready  = (state == S_IDLE) || (state == S_LOAD);
    assign bus.busy      = (state != S_IDLE);
    assign bus.wr_en     = bus.valid_in &&
                           (((state == S_IDLE) && bus.sop_in) || (state == S_LOAD));
    assign bus.wr_addr   = ((state == S_LOAD) && !bus.sop_in) ? bitrev(cnt) : '0;

    assign bus.bf_en     = bf_en_q;
    assign bus.addr_p    = addr_p_q;
    assign bus.addr_q    = addr_q_q;
    assign bus.tw_idx    = tw_q;
    assign bus.stage     = stage_q;
    assign bus.wb_en     = wb_en_sr[BF_LAT-1];
    assign bus.wb_addr_p = wb_p_sr[BF_LAT-1];
    assign bus.wb_addr_q = wb_q_sr[BF_LAT-1];
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.valid_out = rd_en_sr[RD_LAT-1];
    assign bus.sop_out   = rd_sop_sr[RD_LAT-1];
    assign bus.inv_out   = inv_q;
    assign bus.err_sop   = err_q;
    assign bus.dbg_state = state;

    // Frame sequencer: load counting, butterfly schedule, drain gaps, unload.
    // Butterfly and read outputs are loaded on the edge that enters the
    // issuing state, so they line up with the state register cycle for cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            b         <= '0;
            dcnt      <= '0;
            tcnt      <= '0;
            inv_q     <= 1'b0;
            err_q     <= 1'b0;
            bf_en_q   <= 1'b0;
            addr_p_q  <= '0;
            addr_q_q  <= '0;
            tw_q      <= '0;
            stage_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Only a start-of-frame sample opens a frame; it goes to address 0 now.
                    if (bus.valid_in && bus.sop_in) begin
                        state <= S_LOAD;
                        cnt   <= LOGN'(1);
                        inv_q <= bus.inv_in;
                    end
                end
                S_LOAD: begin
                    if (bus.valid_in) begin
                        if (bus.sop_in) begin
                            // Restart: this sample becomes sample 0 of a new frame.
                            err_q <= 1'b1;
                            cnt   <= LOGN'(1);
                            inv_q <= bus.inv_in;
                        end else if (cnt == LOGN'(N - 1)) begin
                            state    <= S_COMPUTE;
                            cnt      <= '0;
                            b        <= '0;
                            stage_q  <= '0;
                            bf_en_q  <= 1'b1;
                            addr_p_q <= calc_p(BW'(0), SW'(0));
                            addr_q_q <= calc_p(BW'(0), SW'(0)) + half_of(SW'(0));
                            tw_q     <= calc_tw(BW'(0), SW'(0));
                        end else begin
                            cnt <= cnt + LOGN'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (b == BW'(N / 2 - 1)) begin
                        state   <= S_DRAIN;
                        bf_en_q <= 1'b0;
                        dcnt    <= '0;
                    end else begin
                        b        <= b_next;
                        bf_en_q  <= 1'b1;
                        addr_p_q <= calc_p(b_next, stage_q);
                        addr_q_q <= calc_p(b_next, stage_q) + half_of(stage_q);
                        tw_q     <= calc_tw(b_next, stage_q);
                    end
                end
                S_DRAIN: begin
                    // Hold issue for BF_LAT cycles so the last write-back precedes the next read.
                    if (dcnt == DW'(BF_LAT - 1)) begin
                        if (stage_q == SW'(LOGN - 1)) begin
                            state     <= S_UNLOAD;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                        end else begin
                            state    <= S_COMPUTE;
                            stage_q  <= stage_next;
                            b        <= '0;
                            bf_en_q  <= 1'b1;
                            addr_p_q <= calc_p(BW'(0), stage_next);
                            addr_q_q <= calc_p(BW'(0), stage_next) + half_of(stage_next);
                            tw_q     <= calc_tw(BW'(0), stage_next);
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                S_UNLOAD: begin
                    if (rd_en_q) begin
                        if (rd_addr_q == LOGN'(N - 1)) begin
                            rd_en_q <= 1'b0;
                            tcnt    <= '0;
                        end else begin
                            rd_addr_q <= rd_addr_q + LOGN'(1);
                        end
                    end else if (tcnt == TW'(RD_LAT - 1)) begin
                        // Last read data has just been presented.
                        state     <= S_IDLE;
                        rd_addr_q <= '0;
                        stage_q   <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-back delay line: butterfly enable and addresses shifted by BF_LAT in every state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_en_sr <= '0;
            wb_p_sr  <= '0;
            wb_q_sr  <= '0;
        end else begin
            wb_en_sr[0] <= bf_en_q;
            wb_p_sr[0]  <= addr_p_q;
            wb_q_sr[0]  <= addr_q_q;
            for (int i = 1; i < BF_LAT; i++) begin
                wb_en_sr[i] <= wb_en_sr[i-1];
                wb_p_sr[i]  <= wb_p_sr[i-1];
                wb_q_sr[i]  <= wb_q_sr[i-1];
            end
        end
    end

    // Read-data qualifier: rd_en and the address-0 marker delayed by the RAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_en_sr  <= '0;
            rd_sop_sr <= '0;
        end else begin
            rd_en_sr[0]  <= rd_en_q;
            rd_sop_sr[0] <= rd_en_q && (rd_addr_q == '0);
            for (int i = 1; i < RD_LAT; i++) begin
                rd_en_sr[i]  <= rd_en_sr[i-1];
                rd_sop_sr[i] <= rd_sop_sr[i-1];
            end
        end
    end
endmodule
